stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Controller for the CPU's 16-bit data-stack memory. It accepts one stack command at a time (PUSH, POP, DROP, DUP, SWAP, OVER) over a valid/ready handshake and tracks the stack depth. It drives the memory's read address, write address, write data and write-enable, and reads back the TOS/NOS operands. It sits between instruction decode and the stack memory and is the only agent allowed to write the stack region.

## Interface
- BASE, 0: word address of the stack bottom (first pushed item).
- DEPTH, 32: stack capacity in words. Constraints: DEPTH ≥ 2 and BASE+DEPTH ≤ 65536.
- c_CLOCK  in  1  the single clock; all state changes on its rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_OPCODE  in  3  command: 0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 DUP, 5 SWAP, 6 OVER, 7 treated as NOP.
- i_IMM  in  16  value to push (PUSH only).
- i_VALID  in  1  command present.
- o_READY  out  1  high only in IDLE; a command is accepted when i_VALID && o_READY.
- o_DONE  out  1  one-cycle pulse when the command completes.
- o_ERROR  out  1  qualified by o_DONE: the command was rejected (underflow or overflow).
- o_RESULT  out  16  valid with o_DONE. POP returns the popped value. Every other command returns the new TOS (0 if the stack is empty).
- o_DEPTH  out  $clog2(DEPTH+1)  current item count.
- o_RADDR  out  16  memory read address: BASE+o_DEPTH-1, or BASE when empty.
- i_OP1  in  16  memory word at o_RADDR. Registered read: valid one cycle after the address is presented.
- i_OP2  in  16  memory word at o_RADDR-1, same timing as i_OP1.
- o_WADDR  out  16  memory write address.
- o_WDATA  out  16  memory write data.
- o_WRITE  out  1  write enable; the memory commits on the edge ending the cycle.

## Operation
- States: IDLE, READ, EXEC, WR2, DONE.
- IDLE: on acceptance, latch the opcode and i_IMM, then run checks against the current depth d.
  - Underflow: POP/DROP/DUP need d≥1; SWAP/OVER need d≥2.
  - Overflow: PUSH/DUP/OVER need d<DEPTH.
  - On error or NOP, go to DONE; o_ERROR=1 on error, no write, depth unchanged.
- Next state after acceptance: PUSH goes to EXEC; every other valid command goes to READ.
- READ: wait one cycle for i_OP1/i_OP2. Capture t=i_OP1 and n=i_OP2 at the end of READ.
- EXEC (one cycle):
  - PUSH: write i_IMM at BASE+d; d+1.
  - DUP: write t at BASE+d; d+1.
  - OVER: write n at BASE+d; d+1.
  - POP/DROP: no write; d-1.
  - SWAP: write n at BASE+d-1, then go to WR2.
- WR2 (SWAP only): write t at BASE+d-2.
- DONE: o_DONE=1 for one cycle, then IDLE.
- Depth is updated on the edge entering DONE. o_RESULT by command:
  - PUSH: i_IMM.
  - DUP: t.
  - OVER: n.
  - SWAP: n.
  - POP: t.
  - DROP: n if d≥2, else 0.
- o_WRITE is asserted only in EXEC (write commands) and WR2, and is forced low while i_RESET=1.
- i_VALID is ignored whenever o_READY=0; commands are never queued.

## Timing
- Acceptance edge = cycle 0. o_DONE is high in:
  - NOP/error: cycle 1.
  - PUSH: cycle 2.
  - POP, DROP, DUP, OVER: cycle 3.
  - SWAP: cycle 4.
- o_READY returns high the cycle after o_DONE, so the earliest next acceptance is at that edge.
- o_RADDR changes only with o_DEPTH. It is therefore stable from acceptance through READ.
- Reset values: state IDLE, o_DEPTH=0, o_READY=1, o_DONE=0, o_ERROR=0, o_RESULT=0, o_WRITE=0, o_WADDR=0, o_WDATA=0, o_RADDR=BASE.
- Reset mid-command: the command is abandoned at the reset edge and no write commits during the reset cycle. A SWAP whose first write already committed leaves memory half-swapped; this is acceptable because depth returns to 0.
- Full stack (d=DEPTH): PUSH/DUP/OVER are rejected, while POP/DROP/SWAP are legal.
- Empty stack (d=0): every command except PUSH and NOP is rejected.
- All address arithmetic is 16-bit. The parameter constraints guarantee no wrap.

## Structure
- Package stack_seq_pkg holds the opcode constants, the state encoding, and per-opcode minimum-depth and net-depth-change constants.
- One sub-module, stack_check: combinational underflow/overflow check from opcode, d and DEPTH.
- Everything else stays in stack_sequencer.

## Test plan
- Reset, then PUSH 0x1234 and PUSH 0xBEEF → o_DONE at cycle 2 each; o_DEPTH=2; mem[BASE]=0x1234, mem[BASE+1]=0xBEEF; o_RESULT=0xBEEF.
- SWAP on [0x1234,0xBEEF] → two single-cycle writes, to BASE+1 then BASE; done at cycle 4; memory holds [0xBEEF,0x1234]; o_RESULT=0x1234.
- DUP then OVER on [0xBEEF,0x1234] → depth 4; memory holds [0xBEEF,0x1234,0x1234,0x1234]; OVER's o_RESULT=0x1234.
- POP on an empty stack → o_DONE+o_ERROR at cycle 1, no o_WRITE, depth 0. Then PUSH DEPTH times, and one further PUSH → error, no write.
- POP with depth 2 holding [7,9] → o_RESULT=9, depth 1. DROP → o_RESULT=0, depth 0.
- Assert i_RESET during SWAP's WR2 cycle → o_WRITE low that cycle; next cycle o_READY=1, o_DEPTH=0. Hold i_VALID high while busy → exactly one command is accepted.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Opcodes, FSM state encoding and per-opcode depth rules shared by the
// data-stack sequencer and its legality checker.
package stack_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DROP = 3'd3;
    localparam logic [2:0] OP_DUP  = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WR2  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Items that must already be on the stack for the opcode to be legal.
    function automatic int min_depth(input logic [2:0] op);
        case (op)
            OP_POP, OP_DROP, OP_DUP: return 1;
            OP_SWAP, OP_OVER:        return 2;
            default:                 return 0;
        endcase
    endfunction

    // Net change of the item count when the opcode completes without error.
    function automatic int depth_delta(input logic [2:0] op);
        case (op)
            OP_PUSH, OP_DUP, OP_OVER: return 1;
            OP_POP, OP_DROP:          return -1;
            default:                  return 0;
        endcase
    endfunction

    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_RSVD);
    endfunction

endpackage

// File: rtl/stack_check.sv
// Combinational legality check of a stack command against the current depth.
module stack_check
    import stack_seq_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic [2:0]    opcode,
    input  logic [DW-1:0] depth,
    output logic          underflow,
    output logic          overflow
);

    logic [7:0] under_vec;
    logic [7:0] over_vec;
    logic       full;

    assign full = (int'(depth) >= DEPTH);

    // Evaluate every opcode in parallel, then pick the one being presented.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rule
            localparam logic [2:0] OP = 3'(gi);
            assign under_vec[gi] = (int'(depth) < min_depth(OP));
            assign over_vec[gi]  = full && (depth_delta(OP) > 0);
        end
    endgenerate

    assign underflow = under_vec[opcode];
    assign overflow  = over_vec[opcode];

endmodule

// File: rtl/stack_sequencer.sv
// Data-stack controller: accepts one stack command at a time, sequences the
// operand read and up to two memory writes, and tracks the stack depth.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int  BASE  = 0,
    parameter int  DEPTH = 32,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          c_CLOCK,
    input  logic          i_RESET,
    input  logic [2:0]    i_OPCODE,
    input  logic [15:0]   i_IMM,
    input  logic          i_VALID,
    output logic          o_READY,
    output logic          o_DONE,
    output logic          o_ERROR,
    output logic [15:0]   o_RESULT,
    output logic [DW-1:0] o_DEPTH,
    output logic [15:0]   o_RADDR,
    input  logic [15:0]   i_OP1,
    input  logic [15:0]   i_OP2,
    output logic [15:0]   o_WADDR,
    output logic [15:0]   o_WDATA,
    output logic          o_WRITE
);

    localparam logic [15:0]   BASE_ADDR = 16'(BASE);
    localparam logic [DW-1:0] TWO_D     = DW'(2);

    state_t        state_reg,  state_next;
    logic [2:0]    op_reg,     op_next;
    logic [15:0]   imm_reg,    imm_next;
    logic [15:0]   t_reg,      t_next;
    logic [15:0]   n_reg,      n_next;
    logic [DW-1:0] depth_reg,  depth_next;
    logic [15:0]   result_reg, result_next;
    logic          error_reg,  error_next;

    logic          underflow;
    logic          overflow;
    logic          reject;
    logic [15:0]   push_addr;
    logic          wr_en;
    logic [15:0]   waddr;
    logic [15:0]   wdata;

    stack_check #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_check (
        .opcode    (i_OPCODE),
        .depth     (depth_reg),
        .underflow (underflow),
        .overflow  (overflow)
    );

    assign reject    = underflow | overflow;
    assign push_addr = BASE_ADDR + 16'(depth_reg);

    always_ff @(posedge c_CLOCK) begin
        if (i_RESET) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_NOP;
            imm_reg    <= '0;
            t_reg      <= '0;
            n_reg      <= '0;
            depth_reg  <= '0;
            result_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            imm_reg    <= imm_next;
            t_reg      <= t_next;
            n_reg      <= n_next;
            depth_reg  <= depth_next;
            result_reg <= result_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        imm_next    = imm_reg;
        t_next      = t_reg;
        n_next      = n_reg;
        depth_next  = depth_reg;
        result_next = result_reg;
        error_next  = error_reg;
        wr_en       = 1'b0;
        waddr       = '0;
        wdata       = '0;
        case (state_reg)
            ST_IDLE: begin
                if (i_VALID) begin
                    op_next    = i_OPCODE;
                    imm_next   = i_IMM;
                    error_next = reject;
                    if (reject || is_nop(i_OPCODE)) begin
                        // Stack is untouched, so the TOS is already on the read port.
                        result_next = (depth_reg == '0) ? '0 : i_OP1;
                        state_next  = ST_DONE;
                    end else if (i_OPCODE == OP_PUSH) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                t_next     = i_OP1;
                n_next     = i_OP2;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_DONE;
                depth_next = depth_reg + DW'(depth_delta(op_reg));
                case (op_reg)
                    OP_PUSH: begin
                        wr_en       = 1'b1;
                        waddr       = push_addr;
                        wdata       = imm_reg;
                        result_next = imm_reg;
                    end
                    OP_DUP: begin
                        wr_en       = 1'b1;
                        waddr       = push_addr;
                        wdata       = t_reg;
                        result_next = t_reg;
                    end
                    OP_OVER: begin
                        wr_en       = 1'b1;
                        waddr       = push_addr;
                        wdata       = n_reg;
                        result_next = n_reg;
                    end
                    OP_POP: begin
                        result_next = t_reg;
                    end
                    OP_DROP: begin
                        result_next = (depth_reg >= TWO_D) ? n_reg : '0;
                    end
                    OP_SWAP: begin
                        wr_en       = 1'b1;
                        waddr       = push_addr - 16'd1;
                        wdata       = n_reg;
                        result_next = n_reg;
                        state_next  = ST_WR2;
                    end
                    default: ;
                endcase
            end
            ST_WR2: begin
                wr_en      = 1'b1;
                waddr      = push_addr - 16'd2;
                wdata      = t_reg;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_READY  = (state_reg == ST_IDLE);
    assign o_DONE   = (state_reg == ST_DONE);
    assign o_ERROR  = o_DONE & error_reg;
    assign o_RESULT = result_reg;
    assign o_DEPTH  = depth_reg;
    assign o_RADDR  = (depth_reg == '0) ? BASE_ADDR : push_addr - 16'd1;
    // Reset must suppress a write even mid-cycle so a half-done command never commits.
    assign o_WRITE  = wr_en & ~i_RESET;
    assign o_WADDR  = waddr;
    assign o_WDATA  = wdata;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a queue-based stack model predicts each
// command's result, error, depth, latency and memory writes.
module tb_stack_sequencer;

    localparam int BASE  = 0;
    localparam int DEPTH = 32;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    opcode;
    logic [15:0]   imm;
    logic          valid;
    logic          ready;
    logic          done;
    logic          error;
    logic [15:0]   result;
    logic [DW-1:0] depth;
    logic [15:0]   raddr;
    logic [15:0]   op1;
    logic [15:0]   op2;
    logic [15:0]   waddr;
    logic [15:0]   wdata;
    logic          write;

    stack_sequencer #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .c_CLOCK  (clk),
        .i_RESET  (rst),
        .i_OPCODE (opcode),
        .i_IMM    (imm),
        .i_VALID  (valid),
        .o_READY  (ready),
        .o_DONE   (done),
        .o_ERROR  (error),
        .o_RESULT (result),
        .o_DEPTH  (depth),
        .o_RADDR  (raddr),
        .i_OP1    (op1),
        .i_OP2    (op2),
        .o_WADDR  (waddr),
        .o_WDATA  (wdata),
        .o_WRITE  (write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stack memory with registered read ports.
    logic [15:0] mem [0:255];
    logic [7:0]  ra_m1;
    assign ra_m1 = 8'(raddr - 16'd1);
    always @(posedge clk) begin
        if (write) mem[waddr[7:0]] <= wdata;
        op1 <= mem[raddr[7:0]];
        op2 <= mem[ra_m1];
    end

    typedef struct {
        int               op;
        logic             err;
        logic [15:0]      res;
        int               depth;
        int               lat;
        int               acc;
        int               nwr;
        logic [1:0][15:0] wa;
        logic [1:0][15:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] stk[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: plain stack semantics on a queue.
    task automatic model(input logic [2:0] op, input logic [15:0] v);
        exp_t        e;
        int          d;
        logic [15:0] popped;
        logic [15:0] t;
        logic [15:0] n;
        d = stk.size();
        popped = '0;
        e.op = int'(op); e.err = 1'b0; e.lat = 1; e.nwr = 0; e.wa = '0; e.wd = '0; e.acc = cyc;
        case (op)
            3'd1: if (d >= DEPTH) e.err = 1'b1;
                  else begin
                      e.lat = 2; e.nwr = 1; e.wa[0] = 16'(BASE + d); e.wd[0] = v; stk.push_back(v);
                  end
            3'd2: if (d < 1) e.err = 1'b1;
                  else begin e.lat = 3; popped = stk.pop_back(); end
            3'd3: if (d < 1) e.err = 1'b1;
                  else begin e.lat = 3; void'(stk.pop_back()); end
            3'd4: if (d < 1 || d >= DEPTH) e.err = 1'b1;
                  else begin
                      t = stk[d-1];
                      e.lat = 3; e.nwr = 1; e.wa[0] = 16'(BASE + d); e.wd[0] = t; stk.push_back(t);
                  end
            3'd5: if (d < 2) e.err = 1'b1;
                  else begin
                      t = stk[d-1]; n = stk[d-2];
                      e.lat = 4; e.nwr = 2;
                      e.wa[0] = 16'(BASE + d - 1); e.wd[0] = n;
                      e.wa[1] = 16'(BASE + d - 2); e.wd[1] = t;
                      stk[d-1] = n; stk[d-2] = t;
                  end
            3'd6: if (d < 2 || d >= DEPTH) e.err = 1'b1;
                  else begin
                      n = stk[d-2];
                      e.lat = 3; e.nwr = 1; e.wa[0] = 16'(BASE + d); e.wd[0] = n; stk.push_back(n);
                  end
            default: ;
        endcase
        e.depth = stk.size();
        if (op == 3'd2 && !e.err) e.res = popped;
        else e.res = (stk.size() == 0) ? 16'h0 : stk[stk.size()-1];
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per o_DONE pulse.
    int          wr_cnt = 0;
    logic [15:0] wa_obs [2];
    logic [15:0] wd_obs [2];
    exp_t        mon_e;
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
        end else begin
            if (write) begin
                if (wr_cnt < 2) begin wa_obs[wr_cnt] = waddr; wd_obs[wr_cnt] = wdata; end
                wr_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("txn op=%0d acc=%0d res=%h err=%b depth=%0d writes=%0d",
                             mon_e.op, mon_e.acc, result, error, depth, wr_cnt);
                    chk("result", result, mon_e.res);
                    chk("error", error, mon_e.err);
                    chk("depth", depth, mon_e.depth);
                    chk("latency", cyc - mon_e.acc, mon_e.lat);
                    chk("write_count", wr_cnt, mon_e.nwr);
                    for (int i = 0; i < 2; i++) begin
                        if (i < mon_e.nwr && i < wr_cnt) begin
                            chk("write_addr", wa_obs[i], mon_e.wa[i]);
                            chk("write_data", wd_obs[i], mon_e.wd[i]);
                        end
                    end
                end
                wr_cnt = 0;
            end
        end
    end

    // Holds i_VALID high with junk while busy; the real command is driven once ready.
    task automatic issue(input logic [2:0] op, input logic [15:0] v);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready && g < 40) begin
            valid = 1'b1; opcode = 3'($urandom); imm = 16'($urandom);
            g++;
            @(negedge clk);
        end
        if (!ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            valid = 1'b0;
        end else begin
            valid = 1'b1; opcode = op; imm = v;
            model(op, v);
        end
    endtask

    task automatic wait_idle();
        int   g;
        logic busy;
        g = 0;
        do begin
            @(negedge clk);
            valid = 1'b0;
            g++;
            busy = (exp_q.size() != 0) || !ready;
        end while (busy && g < 60);
        if (busy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        stk.delete();
    endtask

    task automatic check_mem();
        for (int i = 0; i < stk.size(); i++) chk("mem", mem[8'(BASE + i)], stk[i]);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; opcode = '0; imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_depth", depth, 0);
        chk("rst_write", write, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_raddr", raddr, BASE);
        rst = 1'b0;

        issue(3'd1, 16'h1234);
        issue(3'd1, 16'hBEEF);
        wait_idle();
        check_mem();
        issue(3'd5, 16'h0);
        wait_idle();
        chk("swap_mem0", mem[BASE], 16'hBEEF);
        chk("swap_mem1", mem[BASE+1], 16'h1234);
        issue(3'd4, 16'h0);
        issue(3'd6, 16'h0);
        wait_idle();
        check_mem();

        do_reset();
        issue(3'd2, 16'h0);
        for (int i = 0; i < DEPTH; i++) issue(3'd1, 16'($urandom));
        issue(3'd1, 16'hDEAD);
        issue(3'd4, 16'h0);
        issue(3'd6, 16'h0);
        issue(3'd5, 16'h0);
        issue(3'd2, 16'h0);
        wait_idle();
        check_mem();

        do_reset();
        issue(3'd1, 16'd7);
        issue(3'd1, 16'd9);
        issue(3'd2, 16'h0);
        issue(3'd3, 16'h0);
        issue(3'd3, 16'h0);
        wait_idle();

        for (int k = 0; k < 300; k++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            issue(op, 16'($urandom));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        check_mem();

        // Reset landing in SWAP's second write cycle.
        do_reset();
        issue(3'd1, 16'd7);
        issue(3'd1, 16'd9);
        wait_idle();
        @(negedge clk);
        chk("pre_swap_ready", ready, 1);
        valid = 1'b1; opcode = 3'd5; imm = '0;
        @(negedge clk);
        opcode = 3'd1; imm = 16'h5555;
        @(negedge clk);
        chk("swap_exec_write", write, 1);
        @(negedge clk);
        chk("swap_wr2_write", write, 1);
        rst = 1'b1;
        #1;
        chk("wr2_write_in_reset", write, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        exp_q.delete(); stk.delete();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_depth", depth, 0);
        chk("half_swap_mem0", mem[BASE], 16'd7);
        chk("half_swap_mem1", mem[BASE+1], 16'd7);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
